// File: rtl/ifetch_queue_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_queue_stage_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] rvga_word;

    typedef struct packed {
        rvga_word pc;
        rvga_word inst;
    } fetch_entry_s;

    // Sequential fetch advances by one instruction word.
    localparam rvga_word INST_BYTES = rvga_word'(4);

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_queue_stage_if.sv
// Memory-side and decode-side signals of the fetch stage in one bundle.
interface ifetch_queue_stage_if #(
    parameter int XLEN_P = 32
);
    logic              imem_req_v_o;
    logic              imem_req_ready_i;
    logic [XLEN_P-1:0] imem_addr_o;
    logic              imem_resp_v_i;
    logic [XLEN_P-1:0] imem_resp_data_i;
    logic              inst_v_o;
    logic              inst_ready_i;
    logic [XLEN_P-1:0] inst_o;
    logic [XLEN_P-1:0] pc_o;
    logic              btaken_i;
    logic [XLEN_P-1:0] btarget_i;

    // master: the fetch stage itself
    modport master (
        output imem_req_v_o, imem_addr_o, inst_v_o, inst_o, pc_o,
        input  imem_req_ready_i, imem_resp_v_i, imem_resp_data_i,
               inst_ready_i, btaken_i, btarget_i
    );

    // slave: imem plus decode/branch unit surrounding the stage
    modport slave (
        input  imem_req_v_o, imem_addr_o, inst_v_o, inst_o, pc_o,
        output imem_req_ready_i, imem_resp_v_i, imem_resp_data_i,
               inst_ready_i, btaken_i, btarget_i
    );

endinterface

// File: rtl/ifetch_queue_stage_fifo.sv
// First-word-fall-through queue with synchronous clear; holds fetch entries.
module ifetch_queue_stage_fifo #(
    parameter int  WIDTH_P = 64,
    parameter int  DEPTH_P = 4,
    localparam int CNT_W   = $clog2(DEPTH_P + 1),
    localparam int PTR_W   = $clog2(DEPTH_P)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_clear,
    input  logic [WIDTH_P-1:0] i_data,
    output logic [WIDTH_P-1:0] o_data,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    logic [WIDTH_P-1:0] r_mem [DEPTH_P];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == CNT_W'(DEPTH_P));
    assign o_empty = (r_count == '0);

    // A pop frees the head slot in the same cycle, so push is legal when full.
    assign w_pop  = i_pop && !o_empty && !i_clear;
    assign w_push = i_push && !i_clear && (!o_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue_stage.sv
// Instruction fetch front end: credit-limited sequential requests, in-order
// responses buffered with their PCs, redirect flushes and drops stale responses.
module ifetch_queue_stage
    import ifetch_queue_stage_pkg::*;
#(
    parameter int                XLEN_P     = XLEN,
    parameter int                DEPTH_P    = 4,
    parameter logic [XLEN_P-1:0] RESET_PC_P = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ifetch_queue_stage_if.master bus
);

    localparam int                CNT_W = $clog2(DEPTH_P + 1);
    localparam int                SUM_W = CNT_W + 2;
    localparam logic [XLEN_P-1:0] STEP  = XLEN_P'(INST_BYTES);

    logic [XLEN_P-1:0] r_pc;
    logic [XLEN_P-1:0] r_resp_pc;
    logic [CNT_W-1:0]  r_inflight;
    logic [CNT_W-1:0]  r_drop;
    logic              r_armed;

    logic [XLEN_P-1:0]   w_pc_next;
    logic [XLEN_P-1:0]   w_resp_pc_next;
    logic [CNT_W-1:0]    w_inflight_next;
    logic [CNT_W-1:0]    w_drop_next;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W-1:0]    w_outstanding;
    logic [SUM_W-1:0]    w_credit_sum;
    logic                w_req_v;
    logic                w_req_acc;
    logic                w_resp_drop;
    logic                w_resp_live;
    logic                w_resp_counted;
    logic                w_push;
    logic                w_pop;
    logic                w_inst_v;
    logic [2*XLEN_P-1:0] w_head;
    logic                w_q_full;
    logic                w_q_empty;

    // Queue slots are reserved at request time, so a response always has room.
    assign w_credit_sum = SUM_W'(w_count) + SUM_W'(r_inflight) + SUM_W'(r_drop);
    assign w_req_v      = rst_i && !bus.btaken_i && (w_credit_sum < SUM_W'(DEPTH_P));
    assign w_req_acc    = w_req_v && bus.imem_req_ready_i;

    assign w_outstanding  = r_drop + r_inflight;
    assign w_resp_drop    = bus.imem_resp_v_i && (r_drop != '0);
    assign w_resp_live    = bus.imem_resp_v_i && (r_drop == '0) && (r_inflight != '0);
    assign w_resp_counted = bus.imem_resp_v_i && (w_outstanding != '0);

    assign w_inst_v = rst_i && (w_count != '0) && !bus.btaken_i;
    assign w_pop    = w_inst_v && bus.inst_ready_i;
    assign w_push   = w_resp_live && !bus.btaken_i;

    always_comb begin
        w_pc_next       = r_pc;
        w_resp_pc_next  = r_resp_pc;
        w_inflight_next = r_inflight;
        w_drop_next     = r_drop;
        if (bus.btaken_i) begin
            // Everything still outstanding now belongs to the abandoned stream.
            w_pc_next       = bus.btarget_i;
            w_resp_pc_next  = bus.btarget_i;
            w_inflight_next = '0;
            w_drop_next     = w_outstanding - CNT_W'(w_resp_counted);
        end else begin
            if (w_req_acc) begin
                w_pc_next = r_pc + STEP;
            end
            if (w_push) begin
                w_resp_pc_next = r_resp_pc + STEP;
            end
            w_inflight_next = r_inflight + CNT_W'(w_req_acc) - CNT_W'(w_push);
            w_drop_next     = r_drop - CNT_W'(w_resp_drop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc       <= RESET_PC_P;
            r_resp_pc  <= RESET_PC_P;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_resp_pc  <= w_resp_pc_next;
            r_inflight <= w_inflight_next;
            r_drop     <= w_drop_next;
        end
    end

    // Responses to requests issued before a reset may still trickle in until
    // the first new request is accepted; the stray-response check waits for it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_armed <= 1'b0;
        end else if (w_req_acc) begin
            r_armed <= 1'b1;
        end
    end

    ifetch_queue_stage_fifo #(
        .WIDTH_P (2 * XLEN_P),
        .DEPTH_P (DEPTH_P)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.btaken_i),
        .i_data  ({r_resp_pc, bus.imem_resp_data_i}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    assign bus.imem_req_v_o = w_req_v;
    assign bus.imem_addr_o  = r_pc;
    assign bus.inst_v_o     = w_inst_v;
    assign bus.pc_o         = w_head[2*XLEN_P-1:XLEN_P];
    assign bus.inst_o       = w_head[XLEN_P-1:0];

    a_no_stray_resp: assert property (@(posedge clk_i) disable iff (!rst_i)
        (r_armed && bus.imem_resp_v_i) |-> (w_outstanding != '0));

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
        (w_count <= CNT_W'(DEPTH_P)) && !(w_q_full && w_q_empty));

    a_drop_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
        r_drop <= CNT_W'(DEPTH_P));

endmodule

// File: tb/tb_ifetch_queue_stage.sv
// Scoreboard bench for ifetch_queue_stage: in-order memory model with
// programmable latency, stream epochs to mark responses made stale by redirects.
module tb_ifetch_queue_stage;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic rst_n;

    ifetch_queue_stage_if #(.XLEN_P(32)) bus ();

    ifetch_queue_stage #(
        .XLEN_P     (32),
        .DEPTH_P    (DEPTH),
        .RESET_PC_P (RESET_PC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    req_t mem_q[$];
    exp_t sb[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          epoch    = 0;
    int          n_acc    = 0;
    int          n_pop    = 0;
    logic [31:0] exp_pc   = RESET_PC;

    logic        t_ready, t_inst_ready, t_btaken;
    logic [31:0] t_btarget;

    logic        s_req_v, s_acc, s_inst_v, s_resp_v;
    logic [31:0] s_addr, s_pc, s_inst, last_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later.
    task automatic cycle();
        req_t r;
        exp_t e;
        logic resp_v;
        @(negedge clk);
        bus.imem_req_ready_i = t_ready;
        bus.inst_ready_i     = t_inst_ready;
        bus.btaken_i         = t_btaken;
        bus.btarget_i        = t_btarget;
        resp_v               = 1'b0;
        bus.imem_resp_v_i    = 1'b0;
        bus.imem_resp_data_i = 32'h0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r                    = mem_q.pop_front();
            resp_v               = 1'b1;
            bus.imem_resp_v_i    = 1'b1;
            bus.imem_resp_data_i = mem_word(r.addr);
        end
        #1;
        s_resp_v = resp_v;
        s_req_v  = bus.imem_req_v_o;
        s_addr   = bus.imem_addr_o;
        s_inst_v = bus.inst_v_o;
        s_pc     = bus.pc_o;
        s_inst   = bus.inst_o;
        s_acc    = s_req_v && t_ready;
        if (t_btaken) begin
            check("req_during_redirect", 32'(s_req_v), 32'h0);
            check("instv_during_redirect", 32'(s_inst_v), 32'h0);
        end
        if (s_inst_v && t_inst_ready) begin
            n_pop++;
            last_pop_pc = s_pc;
            $display("pop  cyc=%0d pc=%h inst=%h", cyc, s_pc, s_inst);
            if (sb.size() == 0) begin
                check("pop_unexpected", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                check("pop_pc", s_pc, e.pc);
                check("pop_inst", s_inst, e.inst);
            end
        end
        if (s_acc) begin
            n_acc++;
            check("req_addr", s_addr, exp_pc);
            mem_q.push_back('{exp_pc, cyc + lat, epoch});
            exp_pc = exp_pc + 32'd4;
        end
        if (resp_v && !t_btaken && r.epoch == epoch) begin
            sb.push_back('{r.addr, mem_word(r.addr)});
        end
        if (t_btaken) begin
            sb.delete();
            epoch++;
            exp_pc = t_btarget;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst_n                = 1'b0;
        bus.imem_resp_v_i    = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        bus.btaken_i         = 1'b0;
        mem_q.delete();
        sb.delete();
        epoch++;
        exp_pc = RESET_PC;
        #1;
        check("rst_req_v", 32'(bus.imem_req_v_o), 32'h0);
        check("rst_inst_v", 32'(bus.inst_v_o), 32'h0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int first_acc, first_v, v, a0, p0, p1;
        bit found;
        logic [31:0] first_pc;

        rst_n = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        bus.imem_resp_v_i    = 1'b0;
        bus.imem_resp_data_i = 32'h0;
        bus.inst_ready_i     = 1'b0;
        bus.btaken_i         = 1'b0;
        bus.btarget_i        = 32'h0;
        t_ready = 1'b1; t_inst_ready = 1'b1; t_btaken = 1'b0; t_btarget = 32'h0;
        first_pc = 32'h0;

        // 1: streaming at latency 1
        apply_reset(2);
        lat = 1;
        first_acc = -1; first_v = -1;
        for (int i = 0; i < 20 && first_v < 0; i++) begin
            cycle();
            if (first_acc < 0 && s_acc) first_acc = i;
            if (s_inst_v) begin first_v = i; first_pc = s_pc; end
        end
        check("t1_latency", 32'(first_v - first_acc), 32'd2);
        check("t1_first_pc", first_pc, 32'h0);
        v = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_inst_v) v++;
        end
        check("t1_throughput", 32'(v), 32'd10);

        // 2: decode stalled from the start
        apply_reset(2);
        t_inst_ready = 1'b0;
        a0 = n_acc;
        repeat (12) cycle();
        check("t2_accepts", 32'(n_acc - a0), 32'(DEPTH));
        check("t2_req_stopped", 32'(s_req_v), 32'h0);
        check("t2_head_valid", 32'(s_inst_v), 32'h1);
        t_inst_ready = 1'b1;
        p0 = n_pop;
        for (int i = 0; i < 20 && (n_pop - p0) < DEPTH; i++) cycle();
        check("t2_drained", 32'(n_pop - p0 >= DEPTH), 32'h1);

        // 3: redirect with requests in flight at latency 3
        apply_reset(2);
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (s_acc && s_addr == 32'h18) found = 1'b1;
        end
        check("t3_reach_0x18", 32'(found), 32'h1);
        t_btaken = 1'b1; t_btarget = 32'h100;
        cycle();
        t_btaken = 1'b0;
        cycle();
        check("t3_req_v", 32'(s_req_v), 32'h1);
        check("t3_req_addr", s_addr, 32'h100);
        p0 = n_pop;
        for (int i = 0; i < 20 && n_pop == p0; i++) cycle();
        check("t3_first_pc", last_pop_pc, 32'h100);

        // 4: redirect together with a response and an attempted pop
        lat = 1;
        repeat (10) cycle();
        t_btaken = 1'b1; t_btarget = 32'h400;
        cycle();
        t_btaken = 1'b0;
        check("t4_resp_same_cycle", 32'(s_resp_v), 32'h1);
        cycle();
        check("t4_empty_after", 32'(s_inst_v), 32'h0);
        p0 = n_pop;
        for (int i = 0; i < 20 && n_pop == p0; i++) cycle();
        check("t4_first_pc", last_pop_pc, 32'h400);

        // 5: back-to-back redirects
        lat = 2;
        repeat (8) cycle();
        t_btaken = 1'b1; t_btarget = 32'h200;
        cycle();
        t_btarget = 32'h300;
        cycle();
        t_btaken = 1'b0;
        p0 = n_pop;
        for (int i = 0; i < 20 && n_pop == p0; i++) cycle();
        check("t5_first_pc", last_pop_pc, 32'h300);
        p1 = n_pop;
        repeat (12) cycle();
        check("t5_stream", 32'(n_pop - p1 >= 6), 32'h1);

        // 6: address wrap, then reset with requests outstanding
        t_btaken = 1'b1; t_btarget = 32'hFFFF_FFF8;
        cycle();
        t_btaken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_acc && s_addr == 32'h0) found = 1'b1;
        end
        check("t6_wrap", 32'(found), 32'h1);
        t_inst_ready = 1'b0;
        repeat (6) cycle();
        check("t6_pre_reset_v", 32'(s_inst_v), 32'h1);
        apply_reset(2);
        t_inst_ready = 1'b1;
        lat = 1;
        cycle();
        check("t6_restart_req", 32'(s_acc), 32'h1);
        check("t6_restart_addr", s_addr, RESET_PC);
        repeat (6) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_queue_stage.md
Name: ifetch_queue_stage

Overview:
Parametrised instruction-fetch front end with decoupled memory handshake and a DEPTH_P-entry fetch queue. It issues sequential PC requests to instruction memory under a credit limit and tolerates variable memory latency. It buffers returned instructions with their PCs, and on a taken branch it redirects, flushes the queue and discards stale in-flight responses. It sits between imem and decode, replacing the fixed-latency single-register fetch stage.

Parameters:
XLEN_P, 32, address/instruction width in bits
DEPTH_P, 4, fetch-queue entries and maximum outstanding requests (power of 2, >=2)
RESET_PC_P, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
imem_req_v_o  out  1  fetch request valid
imem_req_ready_i  in  1  imem accepts request this cycle
imem_addr_o  out  XLEN_P  request address (= pc_r)
imem_resp_v_i  in  1  response valid; responses return in request order
imem_resp_data_i  in  XLEN_P  instruction word
inst_v_o  out  1  queue head valid
inst_ready_i  in  1  decode consumes head
inst_o  out  XLEN_P  head instruction
pc_o  out  XLEN_P  head PC
btaken_i  in  1  redirect (taken branch/jump) this cycle
btarget_i  in  XLEN_P  redirect target

Behaviour:
- State: pc_r (next request PC), resp_pc_r (PC of the next valid response), queue (count_r, head/tail pointers), inflight_r (valid outstanding requests), drop_r (stale outstanding requests). Counter width is $clog2(DEPTH_P+1).
- Reset (rst_i=0, async): pc_r=resp_pc_r=RESET_PC_P, queue empty, inflight_r=drop_r=0. While reset is held: imem_req_v_o=0, inst_v_o=0. Deassertion mid-transaction: any late responses are ignored, because drop_r=inflight_r=0 means resp with no outstanding is discarded.
- Credit rule: imem_req_v_o = ~btaken_i && (count_r + inflight_r + drop_r < DEPTH_P). The queue can never overflow.
- Request accept (req_v && ready): pc_r += 4 (mod 2^XLEN_P, wraps), inflight_r++.
- Valid response: if drop_r>0, then drop_r-- and the data is discarded. Otherwise push {resp_pc_r, data}, resp_pc_r += 4, inflight_r--.
- Latency: request accepted at cycle t, response at t+k, so inst_v_o is first asserted at t+k+1. No response-to-output bypass.
- Pop: inst_v_o && inst_ready_i. Simultaneous push and pop is legal at any occupancy, including full.
- inst_v_o = (count_r != 0) && ~btaken_i. inst_o/pc_o come from the head entry and are don't-care when invalid.
- Redirect (btaken_i=1), priority over everything:
  - No request issued that cycle.
  - Queue cleared; any pop is ignored.
  - pc_r=resp_pc_r=btarget_i.
  - drop_r_next = drop_r + inflight_r - (imem_resp_v_i ? 1 : 0).
  - inflight_r_next = 0.
  - The first request from btarget_i is issued in the next cycle.
- Back-to-back redirects: each one restarts from its target. drop_r accumulates and never exceeds DEPTH_P.
- stall is expressed only by inst_ready_i=0. The queue fills, credits are exhausted, and requests stop; nothing is lost.
- Assertions: imem_resp_v_i never arrives while inflight_r+drop_r==0 outside reset recovery; count_r <= DEPTH_P.

Decomposition:
- rvga_types package gains: fetch_entry_s {rvga_word pc; rvga_word inst;} and a shared rvga_word-based increment constant (INST_BYTES = 4).
- One natural sub-module: fifo_queue (width, depth; push/pop/clear, count, head data, async active-low reset) holds the fetch entries.
- PC adders and credit logic stay in ifetch_queue_stage.

Test Plan:
1. Reset release, imem ready=1, 1-cycle response latency, inst_ready_i=1 -> requests to 0x0,0x4,0x8…; inst_v_o first high 2 cycles after the first accept, with pc_o=0x0 and inst_o equal to the returned word; continuous thereafter at 1 inst/cycle.
2. inst_ready_i=0 from cycle 0, DEPTH_P=4 -> exactly 4 requests accepted, imem_req_v_o=0 after; count reaches 4. Releasing ready drains PCs 0x0–0xC in order with no loss and no duplicates.
3. 3-cycle latency, 3 requests in flight (0x10,0x14,0x18), btaken_i with target 0x100 -> those 3 responses are discarded. The next request is 0x100 in the following cycle; the first inst_v_o shows pc_o=0x100.
4. Redirect in the same cycle as a response and a pop -> the response is counted against drop (drop_r = inflight-1), the queue is empty next cycle, and inst_v_o=0 during the redirect cycle.
5. Two redirects in consecutive cycles (0x200 then 0x300) -> only 0x300-stream instructions are ever presented; drop_r returns to 0.
6. pc_r=0xFFFF_FFFC request accepted -> next request address 0x0000_0000. Asserting reset while requests are outstanding clears the queue immediately (inst_v_o=0 asynchronously), and fetch restarts at RESET_PC_P.
